// File: rtl/wm_pkg.sv
// Shared definitions for the watermark insertion controller: FSM state
// encoding and the pixel order inside a 2x2 block.
package wm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WM     = 3'd2,
    ST_INSERT = 3'd3,
    ST_WRITE  = 3'd4,
    ST_NEXT   = 3'd5,
    ST_DONE   = 3'd6
  } wm_state_e;

  // Pixel order inside a block, used for both reads and writes.
  typedef enum logic [1:0] {
    POS_TL = 2'd0,
    POS_TR = 2'd1,
    POS_BL = 2'd2,
    POS_BR = 2'd3
  } blk_pos_e;

  // Address offset of a block pixel relative to the block's top-left pixel.
  function automatic int blk_offset(input logic [1:0] pos, input int img_w);
    int off;
    case (pos)
      POS_TL:  off = 0;
      POS_TR:  off = 1;
      POS_BL:  off = img_w;
      default: off = img_w + 1;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/wm_blk_addr_gen.sv
// Walks 2x2 blocks in row-major order. Keeps the block's top-left pixel
// address incrementally so no multiplier is needed, and counts blocks.
module wm_blk_addr_gen #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          step_i,
  output logic [AW-1:0] base_o,
  output logic [AW-1:0] base_nxt_o,
  output logic [AW-1:0] blk_cnt_o,
  output logic          last_blk_o
);

  logic [AW-1:0] row_q, col_q, base_q, cnt_q;
  logic          col_wrap;

  assign col_wrap   = (col_q == AW'(IMG_W - 2));
  assign last_blk_o = col_wrap && (row_q == AW'(IMG_H - 2));
  // Moving from the last column of a block row jumps over the second pixel row.
  assign base_nxt_o = last_blk_o ? '0 :
                      col_wrap   ? base_q + AW'(IMG_W + 2) :
                                   base_q + AW'(2);
  assign base_o     = base_q;
  assign blk_cnt_o  = cnt_q;

  // Block position and count; cleared at frame start, stepped once per block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q  <= '0;
      col_q  <= '0;
      base_q <= '0;
      cnt_q  <= '0;
    end else if (clr_i) begin
      row_q  <= '0;
      col_q  <= '0;
      base_q <= '0;
      cnt_q  <= '0;
    end else if (step_i) begin
      cnt_q  <= cnt_q + AW'(1);
      base_q <= base_nxt_o;
      col_q  <= col_wrap ? '0 : col_q + AW'(2);
      if (last_blk_o)    row_q <= '0;
      else if (col_wrap) row_q <= row_q + AW'(2);
    end
  end

endmodule

// File: rtl/wm_insert_ctrl.sv
// Frame controller: fetches each 2x2 block, obtains a watermark symbol,
// hands the block to the insertion datapath and writes the result back.
// Handshakes: rd_data is valid the cycle after rd_en; wm_data is taken in
// the cycle wm_ack is high while wm_req is high; ins_valid pulses once per
// block and ins_q* are taken in any cycle ins_ready is high while in INSERT.
module wm_insert_ctrl
  import wm_pkg::*;
#(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [7:0]    rd_data,
  output logic          wm_req,
  input  logic          wm_ack,
  input  logic [1:0]    wm_data,
  output logic          ins_valid,
  output logic [7:0]    ins_d1,
  output logic [7:0]    ins_d2,
  output logic [7:0]    ins_d3,
  output logic [7:0]    ins_d4,
  output logic [1:0]    ins_wm,
  input  logic          ins_ready,
  input  logic [7:0]    ins_q1,
  input  logic [7:0]    ins_q2,
  input  logic [7:0]    ins_q3,
  input  logic [7:0]    ins_q4,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic [AW-1:0] blk_cnt,
  output logic [2:0]    dbg_state
);

  wm_state_e     state_q;
  logic [2:0]    ph_q;
  logic          busy_q, done_q, rd_en_q, wm_req_q, ins_valid_q, wr_en_q;
  logic [AW-1:0] rd_addr_q, wr_addr_q;
  logic [7:0]    wr_data_q;
  logic [1:0]    ins_wm_q;
  logic [7:0]    d_q [4];
  logic [7:0]    q_q [4];

  logic          gen_clr, gen_step, last_blk;
  logic [AW-1:0] base, base_nxt;
  logic [1:0]    cap_idx, nxt_pos;
  logic [AW-1:0] nxt_off, tl_off;

  assign gen_clr  = (state_q == ST_IDLE) && start;
  assign gen_step = (state_q == ST_NEXT) && !abort;
  assign cap_idx  = ph_q[1:0] - 2'd1;
  assign nxt_pos  = ph_q[1:0] + 2'd1;
  assign nxt_off  = AW'(blk_offset(nxt_pos, IMG_W));
  assign tl_off   = AW'(blk_offset(POS_TL, IMG_W));

  wm_blk_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (gen_clr),
    .step_i     (gen_step),
    .base_o     (base),
    .base_nxt_o (base_nxt),
    .blk_cnt_o  (blk_cnt),
    .last_blk_o (last_blk)
  );

  // Main sequencer; every strobe and data output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ph_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      wm_req_q    <= 1'b0;
      ins_valid_q <= 1'b0;
      ins_wm_q    <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        d_q[i] <= '0;
        q_q[i] <= '0;
      end
    end else begin
      ins_valid_q <= 1'b0;
      done_q      <= 1'b0;
      if (abort && (state_q != ST_IDLE)) begin
        state_q  <= ST_IDLE;
        ph_q     <= '0;
        busy_q   <= 1'b0;
        rd_en_q  <= 1'b0;
        wr_en_q  <= 1'b0;
        wm_req_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              state_q   <= ST_FETCH;
              ph_q      <= '0;
              busy_q    <= 1'b1;
              rd_en_q   <= 1'b1;
              rd_addr_q <= tl_off;
            end
          end
          ST_FETCH: begin
            if (ph_q != 3'd0) d_q[cap_idx] <= rd_data;
            if (ph_q < 3'd3) rd_addr_q <= base + nxt_off;
            if (ph_q == 3'd3) rd_en_q <= 1'b0;
            if (ph_q == 3'd4) begin
              state_q  <= ST_WM;
              ph_q     <= '0;
              wm_req_q <= 1'b1;
            end else begin
              ph_q <= ph_q + 3'd1;
            end
          end
          ST_WM: begin
            if (wm_ack) begin
              ins_wm_q    <= wm_data;
              wm_req_q    <= 1'b0;
              ins_valid_q <= 1'b1;
              state_q     <= ST_INSERT;
            end
          end
          ST_INSERT: begin
            if (ins_ready) begin
              q_q[0]    <= ins_q1;
              q_q[1]    <= ins_q2;
              q_q[2]    <= ins_q3;
              q_q[3]    <= ins_q4;
              wr_en_q   <= 1'b1;
              wr_addr_q <= base + tl_off;
              wr_data_q <= ins_q1;
              ph_q      <= '0;
              state_q   <= ST_WRITE;
            end
          end
          ST_WRITE: begin
            if (ph_q < 3'd3) begin
              wr_addr_q <= base + nxt_off;
              wr_data_q <= q_q[nxt_pos];
              ph_q      <= ph_q + 3'd1;
            end else begin
              wr_en_q <= 1'b0;
              ph_q    <= '0;
              state_q <= ST_NEXT;
            end
          end
          ST_NEXT: begin
            if (last_blk) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q   <= ST_FETCH;
              ph_q      <= '0;
              rd_en_q   <= 1'b1;
              rd_addr_q <= base_nxt + tl_off;
            end
          end
          ST_DONE:  state_q <= ST_IDLE;
          default:  state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign wm_req    = wm_req_q;
  assign ins_valid = ins_valid_q;
  assign ins_d1    = d_q[0];
  assign ins_d2    = d_q[1];
  assign ins_d3    = d_q[2];
  assign ins_d4    = d_q[3];
  assign ins_wm    = ins_wm_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_wm_insert_ctrl.sv
// Bench for wm_insert_ctrl: a 4x4 instance for directed scenarios and a
// 32x32 instance for a long frame with repeated start pulses.
module tb_wm_insert_ctrl;
  import wm_pkg::*;

  localparam int AW = 16;
  localparam int W1 = 4;
  localparam int H1 = 4;
  localparam int W2 = 32;
  localparam int H2 = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT 1 (4x4) ----------------
  logic          start, abort, busy, done, rd_en, wm_req, wm_ack, ins_valid, ins_ready, wr_en;
  logic [AW-1:0] rd_addr, wr_addr, blk_cnt;
  logic [7:0]    rd_data, ins_d1, ins_d2, ins_d3, ins_d4, ins_q1, ins_q2, ins_q3, ins_q4, wr_data;
  logic [1:0]    wm_data, ins_wm, sym;
  logic [2:0]    dbg_state;
  logic [7:0]    req_cnt = '0;
  int            ack_delay = 1;

  wm_insert_ctrl #(.IMG_W(W1), .IMG_H(H1), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wm_req(wm_req), .wm_ack(wm_ack), .wm_data(wm_data),
    .ins_valid(ins_valid), .ins_d1(ins_d1), .ins_d2(ins_d2), .ins_d3(ins_d3), .ins_d4(ins_d4),
    .ins_wm(ins_wm), .ins_ready(ins_ready),
    .ins_q1(ins_q1), .ins_q2(ins_q2), .ins_q3(ins_q3), .ins_q4(ins_q4),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .blk_cnt(blk_cnt), .dbg_state(dbg_state)
  );

  // Image memory holds its own address; insertion adds 1 to each pixel.
  always @(posedge clk) if (rd_en) rd_data <= rd_addr[7:0];
  always @(posedge clk) req_cnt <= wm_req ? req_cnt + 8'd1 : 8'd0;
  assign wm_ack  = wm_req && (int'(req_cnt) >= ack_delay - 1);
  assign wm_data = sym;
  assign ins_q1  = ins_d1 + 8'd1;
  assign ins_q2  = ins_d2 + 8'd1;
  assign ins_q3  = ins_d3 + 8'd1;
  assign ins_q4  = ins_d4 + 8'd1;

  // ---------------- DUT 2 (32x32) ----------------
  logic          start2, busy2, done2, rd_en2, wm_req2, ins_valid2, wr_en2;
  logic [AW-1:0] rd_addr2, wr_addr2, blk_cnt2;
  logic [7:0]    rd_data2, d2_1, d2_2, d2_3, d2_4, wr_data2;
  logic [1:0]    ins_wm2;
  logic [2:0]    dbg_state2;

  wm_insert_ctrl #(.IMG_W(W2), .IMG_H(H2), .AW(AW)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0), .busy(busy2), .done(done2),
    .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
    .wm_req(wm_req2), .wm_ack(wm_req2), .wm_data(2'b10),
    .ins_valid(ins_valid2), .ins_d1(d2_1), .ins_d2(d2_2), .ins_d3(d2_3), .ins_d4(d2_4),
    .ins_wm(ins_wm2), .ins_ready(1'b1),
    .ins_q1(d2_1 + 8'd1), .ins_q2(d2_2 + 8'd1), .ins_q3(d2_3 + 8'd1), .ins_q4(d2_4 + 8'd1),
    .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2), .blk_cnt(blk_cnt2), .dbg_state(dbg_state2)
  );

  always @(posedge clk) if (rd_en2) rd_data2 <= rd_addr2[7:0];

  // ---------------- monitors / scoreboard ----------------
  logic [23:0]   wr_q[$];
  logic [23:0]   wr2_q[$];
  logic [AW-1:0] rd_q[$];
  logic [1:0]    wm_q[$];
  logic [31:0]   d_q[$];
  int            run_q[$];
  logic [23:0]   exp_q[$];
  int run = 0, done_cnt = 0, done2_cnt = 0, overlap_cnt = 0;
  int checks = 0, errors = 0;

  always @(negedge clk) begin
    if (wr_en) wr_q.push_back({wr_addr, wr_data});
    if (rd_en) rd_q.push_back(rd_addr);
    if (done) done_cnt++;
    if (ins_valid) begin
      wm_q.push_back(ins_wm);
      d_q.push_back({ins_d1, ins_d2, ins_d3, ins_d4});
    end
    if ((rd_en && wr_en) || (rd_en && wm_req) || (wr_en && wm_req)) overlap_cnt++;
    if (wm_req) run++;
    else if (run != 0) begin
      run_q.push_back(run);
      run = 0;
    end
    if (wr_en2) wr2_q.push_back({wr_addr2, wr_data2});
    if (done2) done2_cnt++;
  end

  task automatic clear_logs();
    wr_q.delete(); rd_q.delete(); wm_q.delete(); d_q.delete(); run_q.delete();
    done_cnt = 0; overlap_cnt = 0;
  endtask

  // Expected write stream of a whole frame: block order row-major, pixels TL,TR,BL,BR.
  task automatic build_exp(input int w, input int h);
    logic [15:0] a;
    int off [4];
    exp_q.delete();
    off[0] = 0; off[1] = 1; off[2] = w; off[3] = w + 1;
    for (int r = 0; r < h; r += 2)
      for (int c = 0; c < w; c += 2)
        for (int k = 0; k < 4; k++) begin
          a = 16'(r * w + c + off[k]);
          exp_q.push_back({a, a[7:0] + 8'd1});
        end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL %s: no done within %0d cycles", name, budget);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if ({busy, done, rd_en, wr_en, wm_req, ins_valid} !== 6'b0) begin
      errors++; $display("FAIL reset_strobes: got %b want 000000", {busy, done, rd_en, wr_en, wm_req, ins_valid});
    end
    checks++;
    if (blk_cnt !== '0 || rd_addr !== '0 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL reset_regs: blk_cnt %0d rd_addr %0d state %0d want 0", blk_cnt, rd_addr, dbg_state);
    end
    checks++;
    if (rd_q.size() != 0) begin
      errors++; $display("FAIL no_autostart: reads %0d want 0", rd_q.size());
    end
  endtask

  task automatic test_full_frame();
    clear_logs();
    sym = 2'b01;
    build_exp(W1, H1);
    pulse_start();
    #1;
    checks++;
    if (busy !== 1'b1 || dbg_state !== ST_FETCH || rd_en !== 1'b1 || rd_addr !== '0) begin
      errors++; $display("FAIL start_accept: busy %b state %0d rd_en %b rd_addr %0d want 1 1 1 0", busy, dbg_state, rd_en, rd_addr);
    end
    wait_done(400, "frame4_done");
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (wr_q.size() != 16 || rd_q.size() != 16) begin
      errors++; $display("FAIL frame4_counts: writes %0d reads %0d want 16 16", wr_q.size(), rd_q.size());
    end
    for (int i = 0; i < 16 && i < wr_q.size() && i < rd_q.size(); i++) begin
      checks++;
      if (wr_q[i] !== exp_q[i] || rd_q[i] !== exp_q[i][23:8]) begin
        errors++;
        $display("FAIL frame4_xfer[%0d]: wr %h rd %h want wr %h rd %h", i, wr_q[i], rd_q[i], exp_q[i], exp_q[i][23:8]);
      end
    end
    checks++;
    if (done_cnt != 1 || blk_cnt !== 16'd4 || busy !== 1'b0) begin
      errors++; $display("FAIL frame4_end: done %0d blk_cnt %0d busy %b want 1 4 0", done_cnt, blk_cnt, busy);
    end
    checks++;
    if (d_q.size() < 1 || d_q[0] !== {8'd0, 8'd1, 8'd4, 8'd5}) begin
      errors++; $display("FAIL blk0_pixels: got %h want 00010405", (d_q.size() > 0) ? d_q[0] : 32'hx);
    end
    checks++;
    if (run_q.size() != 4 || wm_q.size() != 4) begin
      errors++; $display("FAIL wm_imm_count: runs %0d syms %0d want 4 4", run_q.size(), wm_q.size());
    end
    for (int i = 0; i < run_q.size(); i++) begin
      checks++;
      if (run_q[i] != 1 || wm_q[i] !== 2'b01) begin
        errors++; $display("FAIL wm_imm[%0d]: req cycles %0d sym %0d want 1 1", i, run_q[i], wm_q[i]);
      end
    end
  endtask

  // Relies on the logs of the preceding full frame.
  task automatic test_block_order();
    logic [15:0] want [4];
    want[0] = 16'd2; want[1] = 16'd3; want[2] = 16'd6; want[3] = 16'd7;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rd_q.size() < 8 || wr_q.size() < 8 || rd_q[4 + k] !== want[k] || wr_q[4 + k][23:8] !== want[k]) begin
        errors++; $display("FAIL blk02_order[%0d]: rd %0d wr %0d want %0d", k,
                           (rd_q.size() > 4 + k) ? rd_q[4 + k] : 16'hx, (wr_q.size() > 4 + k) ? wr_q[4 + k][23:8] : 16'hx, want[k]);
      end
    end
    checks++;
    if (d_q.size() < 2 || d_q[1] !== {8'd2, 8'd3, 8'd6, 8'd7}) begin
      errors++; $display("FAIL blk02_pixels: got %h want 02030607", (d_q.size() > 1) ? d_q[1] : 32'hx);
    end
  endtask

  task automatic test_wm_delay();
    clear_logs();
    ack_delay = 10;
    sym = 2'b11;
    build_exp(W1, H1);
    pulse_start();
    wait_done(800, "wm_delay_done");
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (run_q.size() != 4) begin
      errors++; $display("FAIL wm_delay_runs: got %0d want 4", run_q.size());
    end
    for (int i = 0; i < run_q.size(); i++) begin
      checks++;
      if (run_q[i] != 10 || wm_q[i] !== 2'b11) begin
        errors++; $display("FAIL wm_delay[%0d]: req cycles %0d sym %0d want 10 3", i, run_q[i], wm_q[i]);
      end
    end
    checks++;
    if (overlap_cnt != 0) begin
      errors++; $display("FAIL strobe_overlap: got %0d want 0", overlap_cnt);
    end
    checks++;
    if (wr_q.size() != 16 || (wr_q.size() == 16 && wr_q[15] !== exp_q[15])) begin
      errors++; $display("FAIL wm_delay_writes: count %0d want 16", wr_q.size());
    end
    ack_delay = 1;
  endtask

  task automatic test_abort_write();
    int n = 0;
    clear_logs();
    pulse_start();
    while (wr_q.size() < 7 && n < 400) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (wr_q.size() != 7 || dbg_state !== ST_WRITE || blk_cnt !== 16'd1) begin
      errors++; $display("FAIL abort_setup: writes %0d state %0d blk_cnt %0d want 7 %0d 1", wr_q.size(), dbg_state, blk_cnt, ST_WRITE);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (dbg_state !== ST_IDLE || busy !== 1'b0 || wr_en !== 1'b0 || rd_en !== 1'b0 || wm_req !== 1'b0) begin
      errors++; $display("FAIL abort_idle: state %0d busy %b wr_en %b rd_en %b wm_req %b want 0 0 0 0 0", dbg_state, busy, wr_en, rd_en, wm_req);
    end
    repeat (40) @(negedge clk);
    #1;
    checks++;
    if (wr_q.size() != 7 || done_cnt != 0 || blk_cnt !== 16'd1 || rd_q.size() != 8) begin
      errors++; $display("FAIL abort_after: writes %0d done %0d blk_cnt %0d reads %0d want 7 0 1 8", wr_q.size(), done_cnt, blk_cnt, rd_q.size());
    end
  endtask

  task automatic test_abort_wm();
    int n = 0;
    clear_logs();
    pulse_start();
    while (wm_req !== 1'b1 && n < 100) begin
      @(negedge clk); #1; n++;
    end
    abort = 1'b1;
    checks++;
    if (wm_ack !== 1'b1) begin
      errors++; $display("FAIL abort_wm_setup: wm_ack %b want 1", wm_ack);
    end
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (dbg_state !== ST_IDLE || ins_valid !== 1'b0 || busy !== 1'b0 || wm_req !== 1'b0) begin
      errors++; $display("FAIL abort_wm: state %0d ins_valid %b busy %b wm_req %b want 0 0 0 0", dbg_state, ins_valid, busy, wm_req);
    end
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (wm_q.size() != 0 || wr_q.size() != 0) begin
      errors++; $display("FAIL abort_wm_after: syms %0d writes %0d want 0 0", wm_q.size(), wr_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_logs();
    ins_ready = 1'b0;
    sym = 2'b10;
    pulse_start();
    while (!(ins_valid === 1'b1 && blk_cnt === 16'd1) && n < 400) begin
      @(negedge clk); #1; n++;
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (dbg_state !== ST_INSERT || ins_wm !== 2'b10) begin
      errors++; $display("FAIL rst_setup: state %0d ins_wm %0d want %0d 2", dbg_state, ins_wm, ST_INSERT);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, rd_en, wr_en, wm_req, ins_valid} !== 6'b0 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL rst_mid_strobes: got %b state %0d want 000000 0", {busy, done, rd_en, wr_en, wm_req, ins_valid}, dbg_state);
    end
    checks++;
    if ({ins_d1, ins_d2, ins_d3, ins_d4} !== 32'd0 || ins_wm !== 2'd0 || blk_cnt !== '0 ||
        rd_addr !== '0 || wr_addr !== '0 || wr_data !== '0) begin
      errors++; $display("FAIL rst_mid_data: d %h wm %0d blk_cnt %0d rd_addr %0d wr_addr %0d wr_data %0d want 0",
                         {ins_d1, ins_d2, ins_d3, ins_d4}, ins_wm, blk_cnt, rd_addr, wr_addr, wr_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ins_ready = 1'b1;
    clear_logs();
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (rd_q.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_no_restart: reads %0d busy %b want 0 0", rd_q.size(), busy);
    end
    build_exp(W1, H1);
    pulse_start();
    wait_done(400, "rst_restart_done");
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (rd_q.size() < 1 || rd_q[0] !== '0 || wr_q.size() != 16 || blk_cnt !== 16'd4) begin
      errors++; $display("FAIL rst_restart: first rd %0d writes %0d blk_cnt %0d want 0 16 4",
                         (rd_q.size() > 0) ? rd_q[0] : 16'hx, wr_q.size(), blk_cnt);
    end
  endtask

  task automatic test_big_frame();
    int n = 0;
    int bad = 0;
    wr2_q.delete();
    done2_cnt = 0;
    build_exp(W2, H2);
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    while (done2_cnt == 0 && n < 6000) begin
      @(negedge clk);
      start2 = (n % 50 == 25) ? 1'b1 : 1'b0;
      #1;
      n++;
    end
    start2 = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    checks++;
    if (done2_cnt != 1 || blk_cnt2 !== 16'd256 || busy2 !== 1'b0) begin
      errors++; $display("FAIL big_end: done %0d blk_cnt %0d busy %b want 1 256 0", done2_cnt, blk_cnt2, busy2);
    end
    checks++;
    if (wr2_q.size() != 1024) begin
      errors++; $display("FAIL big_writes: got %0d want 1024", wr2_q.size());
    end
    for (int i = 0; i < wr2_q.size() && i < exp_q.size(); i++)
      if (wr2_q[i] !== exp_q[i]) begin
        if (bad == 0) $display("first big_stream difference at %0d: got %h want %h", i, wr2_q[i], exp_q[i]);
        bad++;
      end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL big_stream: %0d entries differ, want 0", bad);
    end
  endtask

  initial begin
    start = 1'b0; abort = 1'b0; ins_ready = 1'b1; sym = 2'b00; start2 = 1'b0;
    test_reset();
    test_full_frame();
    test_block_order();
    test_wm_delay();
    test_abort_write();
    test_abort_wm();
    test_reset_mid();
    test_big_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wm_insert_ctrl.md
WM_INSERT_CTRL -- requirements
Module: wm_insert_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 256, image width in pixels (even, >=2).
REQ-002 SHALL have parameter IMG_H, default 256, image height in pixels (even, >=2).
REQ-003 SHALL have parameter AW, default 16, pixel address width; IMG_W*IMG_H <= 2^AW.
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  in  1  one-cycle pulse; begins a frame when idle.
REQ-007 SHALL have port abort  in  1  synchronous; terminates the frame.
REQ-008 SHALL have port busy  out  1  high from start acceptance until done or abort.
REQ-009 SHALL have port done  out  1  one-cycle pulse after the last block is written.
REQ-010 SHALL have port rd_en  out  1  pixel read strobe to image memory.
REQ-011 SHALL have port rd_addr  out  AW  read address, row-major (row*IMG_W+col).
REQ-012 SHALL have port rd_data  in  8  read data, valid exactly 1 cycle after rd_en.
REQ-013 SHALL have port wm_req  out  1  request for the next 2-bit watermark symbol.
REQ-014 SHALL have port wm_ack  in  1  symbol valid on wm_data this cycle.
REQ-015 SHALL have port wm_data  in  2  watermark symbol.
REQ-016 SHALL have port ins_valid  out  1  one-cycle pulse; block presented to insertion datapath.
REQ-017 SHALL have ports ins_d1..ins_d4  out  8 each  block pixels (TL, TR, BL, BR).
REQ-018 SHALL have port ins_wm  out  2  symbol for the presented block.
REQ-019 SHALL have port ins_ready  in  1  insertion result valid on ins_q1..ins_q4.
REQ-020 SHALL have ports ins_q1..ins_q4  in  8 each  watermarked pixels (TL, TR, BL, BR).
REQ-021 SHALL have ports wr_en out 1, wr_addr out AW, wr_data out 8  write port to output memory.
REQ-022 SHALL have port blk_cnt  out  AW  number of blocks completed in the current frame.

Function
REQ-023 SHALL implement states IDLE, FETCH, WM, INSERT, WRITE, NEXT, DONE.
REQ-024 IDLE: start=1 SHALL load row=0, col=0, blk_cnt=0, assert busy, go to FETCH next cycle; start ignored in any other state.
REQ-025 FETCH SHALL issue 4 consecutive reads (TL, TR, BL, BR) and capture each rd_data one cycle later into ins_d1..4; last capture cycle -> WM (FETCH = 5 cycles).
REQ-026 WM SHALL hold wm_req=1 until wm_ack=1, latch wm_data to ins_wm that cycle, -> INSERT; no cycle limit.
REQ-027 INSERT SHALL pulse ins_valid on entry only, hold ins_d*/ins_wm stable, wait for ins_ready, latch ins_q1..4, -> WRITE; ins_ready in entry cycle accepted.
REQ-028 WRITE SHALL write 4 consecutive cycles to the same 4 addresses and order as FETCH, -> NEXT.
REQ-029 NEXT SHALL increment blk_cnt; col+=2; at col=IMG_W-2 wrap col=0, row+=2; after block at (IMG_H-2, IMG_W-2) -> DONE, else -> FETCH.
REQ-030 DONE SHALL pulse done for one cycle, deassert busy, -> IDLE; blk_cnt holds (IMG_W*IMG_H)/4 until next start.
REQ-031 abort=1 in any non-IDLE state SHALL -> IDLE next cycle, drop busy, rd_en, wr_en, wm_req, suppress done; blk_cnt holds; abort wins over wm_ack/ins_ready same cycle.
REQ-032 Address arithmetic SHALL be AW bits unsigned; no wrap within a legal frame.
REQ-033 rd_en, wr_en, wm_req SHALL never be high simultaneously.

Reset
REQ-034 rst_n=0 SHALL asynchronously force IDLE and all outputs, counters and data registers to 0, including mid-frame.
REQ-035 After rst_n deasserts, no frame SHALL start without a new start pulse.

Structure
REQ-036 State encoding constants and block-order (TL/TR/BL/BR) offsets SHALL live in a shared package wm_pkg.
REQ-037 Row/column/block counting SHALL be one sub-module wm_blk_addr_gen (step, wrap, last_blk flags).

Verification
REQ-038 4x4 image, memory = address, wm_ack and ins_ready immediate, q=d+1 -> 4 blocks, 16 writes data=addr+1, done once, blk_cnt=4.
REQ-039 Block (0,2) of 4x4 -> reads in order 2,3,6,7; writes in same order.
REQ-040 wm_ack delayed 10 cycles -> wm_req high exactly 10 cycles, no reads/writes meanwhile, ins_wm equals acked symbol.
REQ-041 abort on third WRITE cycle of block 2 -> IDLE next cycle, no done, blk_cnt=1, no further writes.
REQ-042 rst_n low mid-INSERT -> all outputs 0 immediately; start afterwards restarts at address 0.
REQ-043 start pulses while busy -> ignored; full 256x256 frame -> done once, blk_cnt=16384.
